// File: rtl/mac_engine.sv
// rtl/mac_engine.sv - pipelined signed multiply-accumulate engine with tagged, shifted, saturating result
module mac_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 4,
    parameter int LEN    = 8,
    parameter int ADDR_W = 3,
    parameter int SAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [OUT_W-1:0]  out_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              ovf_o
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam int PROD_W = 2 * DATA_W;
    // Comparison width wide enough to hold both the shifted accumulator and the output range bounds.
    localparam int WW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [WW-1:0] MAX_V = (WW'(1) << (OUT_W - 1)) - WW'(1);
    localparam logic signed [WW-1:0] MIN_V = -(WW'(1) << (OUT_W - 1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [ADDR_W-1:0]         tag_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      prod_vld_q;
    logic                      acc_vld_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      sticky_q;
    logic [OUT_W-1:0]          out_q;
    logic [ADDR_W-1:0]         out_addr_q;
    logic                      out_valid_q;
    logic                      ovf_q;

    logic                      accept;
    logic                      last;
    logic                      drained;
    logic signed [PROD_W-1:0]  a_ext, b_ext;
    logic signed [ACC_W-1:0]   prod_ext, sum, shifted;
    logic                      add_ovf;
    logic signed [WW-1:0]      r_w;
    logic                      clamp_hi, clamp_lo;
    logic [OUT_W-1:0]          res;

    assign accept   = (state_q == S_RUN) && in_valid_i;
    assign last     = accept && (cnt_q == CNT_W'(LEN - 1));
    assign drained  = !prod_vld_q && !acc_vld_q;
    assign a_ext    = PROD_W'($signed(a_i));
    assign b_ext    = PROD_W'($signed(b_i));
    assign prod_ext = ACC_W'(prod_q);
    assign sum      = acc_q + prod_ext;
    // Signed overflow: both addends share a sign that the sum does not.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign shifted  = acc_q >>> SHIFT;
    assign r_w      = WW'(shifted);
    assign clamp_hi = (SAT != 0) && (r_w > MAX_V);
    assign clamp_lo = (SAT != 0) && (r_w < MIN_V);
    assign res      = clamp_hi ? MAX_V[OUT_W-1:0] : (clamp_lo ? MIN_V[OUT_W-1:0] : r_w[OUT_W-1:0]);

    assign out_o       = out_q;
    assign out_addr_o  = out_addr_q;
    assign out_valid_o = out_valid_q;
    assign ovf_o       = ovf_q;

    // Next-state and handshake decode.
    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        busy_o     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN: begin
                in_ready_o = 1'b1;
                if (last) state_d = S_DRAIN;
            end
            S_DRAIN: if (drained) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, multiply stage, accumulate stage and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_vld_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_q       <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            prod_vld_q  <= accept;
            acc_vld_q   <= prod_vld_q;
            if (state_q == S_IDLE && start_i) begin
                tag_q    <= addr_i;
                acc_q    <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end
            if (accept) begin
                prod_q <= a_ext * b_ext;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (prod_vld_q) begin
                acc_q <= sum;
                if (add_ovf) sticky_q <= 1'b1;
            end
            if (state_q == S_DRAIN && drained) begin
                out_q       <= res;
                out_addr_q  <= tag_q;
                ovf_q       <= sticky_q | clamp_hi | clamp_lo;
                out_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mac_engine.sv
// tb/tb_mac_engine.sv - scoreboard bench for mac_engine across four parameter sets
module tb_mac_engine;
    typedef struct {
        int inst;
        int out;
        int addr;
        int ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s[4];
    logic [2:0] addr_s[4];
    logic [7:0] a_s[4], b_s[4];
    logic       in_valid_s[4], in_ready_s[4];
    logic [15:0] out_s[4];
    logic [2:0] out_addr_s[4];
    logic       out_valid_s[4], busy_s[4], ovf_s[4];

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    task automatic chk(string nm, longint act, longint expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Instance 0: defaults; 1: SHIFT=0 SAT=1; 2: SHIFT=0 SAT=0; 3: LEN=1.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mac_engine #(
            .SHIFT((g == 1 || g == 2) ? 0 : 4),
            .SAT  ((g == 2) ? 0 : 1),
            .LEN  ((g == 3) ? 1 : 8)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .start_i    (start_s[g]),
            .addr_i     (addr_s[g]),
            .a_i        (a_s[g]),
            .b_i        (b_s[g]),
            .in_valid_i (in_valid_s[g]),
            .in_ready_o (in_ready_s[g]),
            .out_o      (out_s[g]),
            .out_addr_o (out_addr_s[g]),
            .out_valid_o(out_valid_s[g]),
            .busy_o     (busy_s[g]),
            .ovf_o      (ovf_s[g])
        );

        always @(negedge clk) begin
            if (out_valid_s[g]) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: inst %0d out %0d expected no result", g, out_s[g]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_inst", g, e.inst);
                    chk("out", out_s[g], e.out);
                    chk("out_addr", out_addr_s[g], e.addr);
                    chk("ovf", ovf_s[g], e.ovf);
                end
            end
        end
    end

    function automatic exp_t model(int k, int addr, int av[8], int bv[8]);
        exp_t   e;
        int     len = (k == 3) ? 1 : 8;
        int     sh  = (k == 1 || k == 2) ? 0 : 4;
        int     sat = (k == 2) ? 0 : 1;
        longint acc = 0;
        longint r;
        int     ovf = 0;
        for (int i = 0; i < len; i++) begin
            acc = acc + av[i] * bv[i];
            if (acc > 524287) begin acc = acc - 1048576; ovf = 1; end
            else if (acc < -524288) begin acc = acc + 1048576; ovf = 1; end
        end
        r = acc >>> sh;
        if (sat != 0 && r > 32767) begin r = 32767; ovf = 1; end
        else if (sat != 0 && r < -32768) begin r = -32768; ovf = 1; end
        e.inst = k;
        e.out  = int'(r & 64'hFFFF);
        e.addr = addr;
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic op(int k, int addr, int av[8], int bv[8], bit bubble, bit glitch, int abort_after);
        int len = (k == 3) ? 1 : 8;
        int i = 0;
        int cyc = 0;
        bit acc;
        if (abort_after == 0) exp_q.push_back(model(k, addr, av, bv));
        @(posedge clk); #1;
        start_s[k] = 1'b1;
        addr_s[k]  = 3'(addr);
        in_valid_s[k] = 1'b1;
        a_s[k] = 8'h7F;
        b_s[k] = 8'h7F;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        chk("busy_after_start", busy_s[k], 1);
        while (i < len && cyc < 100) begin
            in_valid_s[k] = bubble ? ((cyc % 2) == 0) : 1'b1;
            a_s[k] = 8'(av[i]);
            b_s[k] = 8'(bv[i]);
            start_s[k] = glitch && (cyc == 2);
            addr_s[k]  = (glitch && cyc == 2) ? 3'(addr ^ 7) : 3'(addr);
            @(negedge clk);
            acc = in_valid_s[k] && in_ready_s[k];
            @(posedge clk); #1;
            start_s[k] = 1'b0;
            if (acc) i++;
            cyc++;
            if (abort_after != 0 && i == abort_after) begin
                in_valid_s[k] = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_busy", busy_s[k], 0);
                chk("abort_in_ready", in_ready_s[k], 0);
                chk("abort_out", out_s[k], 0);
                repeat (12) @(posedge clk);
                #1;
                return;
            end
        end
        in_valid_s[k] = 1'b0;
        if (cyc >= 100) chk("accept_timeout", i, len);
        chk("in_ready_after_last", in_ready_s[k], 0);
        repeat (2) @(posedge clk);
        #1;
        chk("out_valid_early", out_valid_s[k], 0);
        @(posedge clk); #1;
        chk("out_valid_latency", out_valid_s[k], 1);
        chk("busy_during_out", busy_s[k], 1);
        @(posedge clk); #1;
        chk("busy_after_out", busy_s[k], 0);
        chk("out_valid_pulse", out_valid_s[k], 0);
    endtask

    initial begin
        int av[8], bv[8];
        for (int k = 0; k < 4; k++) begin
            start_s[k] = 1'b0; addr_s[k] = '0; a_s[k] = '0; b_s[k] = '0; in_valid_s[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_out", out_s[k], 0);
            chk("rst_busy", busy_s[k], 0);
            chk("rst_in_ready", in_ready_s[k], 0);
            chk("rst_out_valid", out_valid_s[k], 0);
            chk("rst_ovf", ovf_s[k], 0);
            chk("rst_out_addr", out_addr_s[k], 0);
        end
        rst = 1'b0;

        foreach (av[i]) begin av[i] = 16; bv[i] = 16; end
        op(0, 5, av, bv, 0, 0, 0);
        foreach (av[i]) begin av[i] = -3; bv[i] = 5; end
        op(0, 3, av, bv, 0, 0, 0);
        foreach (av[i]) begin av[i] = 16; bv[i] = 16; end
        op(0, 5, av, bv, 1, 0, 0);
        foreach (av[i]) begin av[i] = 127; bv[i] = 127; end
        op(1, 6, av, bv, 0, 0, 0);
        op(2, 1, av, bv, 1, 0, 0);
        foreach (av[i]) begin av[i] = 16; bv[i] = 16; end
        op(0, 4, av, bv, 0, 0, 4);
        op(0, 5, av, bv, 0, 0, 0);
        op(0, 2, av, bv, 0, 1, 0);
        av[0] = -128; bv[0] = -128;
        op(3, 7, av, bv, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            int k = int'($urandom_range(0, 3));
            foreach (av[i]) begin
                av[i] = int'($urandom_range(0, 255)) - 128;
                bv[i] = int'($urandom_range(0, 255)) - 128;
            end
            op(k, int'($urandom_range(0, 7)), av, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(posedge clk);
        chk("results_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
